alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream issue and completion stage for the 4-bit ALU (3-bit sel, 5-bit registered result, 1-cycle latency, no stall input).
- Accepts tagged operation commands over a valid/ready handshake and buffers them in a command FIFO.
- Issues at most one command per cycle to the ALU, using credits so every issued result has a guaranteed result-buffer slot.
- Returns results, tag and exception flags downstream over a valid/ready handshake.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RES_DEPTH, 2, result buffer entries (power of 2, >=2)
TAG_W, 4, width of the command tag

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  command valid
in_ready  out  1  command FIFO not full
in_a  in  4  operand A
in_b  in  4  operand B
in_sel  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 xor, 110 mod, 111 div
in_tag  in  TAG_W  command tag
alu_a  out  4  operand A to ALU
alu_b  out  4  operand B to ALU
alu_sel  out  3  opcode to ALU
alu_result  in  5  ALU registered result, valid 1 cycle after issue
out_valid  out  1  result buffer not empty
out_ready  in  1  downstream accepts
out_result  out  5  result (0 when out_dz=1)
out_tag  out  TAG_W  tag of the command
out_dz  out  1  mod/div with B==0
out_ovf  out  1  add carry beyond 5 bits impossible; set for mul with A*B>31 or sub with B>A
cmd_count  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy

Behaviour:
- Reset (reset==0 at a clock edge): both FIFOs are emptied, the in-flight flag is cleared, and the credit count is set to RES_DEPTH.
  - in_ready=0 while reset==0. in_ready=1 in the first cycle after release.
  - out_valid=0, cmd_count=0.
  - alu_a/alu_b/alu_sel=0. out_result/out_tag/out_dz/out_ovf=0.
- Input accept: when in_valid && in_ready, the command is written to the command FIFO.
  - dz and ovf are precomputed at accept time and stored with the entry.
  - A command accepted at edge N can issue no earlier than the cycle after edge N (1-cycle fall-through minimum).
- Issue: issue_fire = cmd FIFO not empty && credits>0.
  - alu_a/alu_b/alu_sel are driven combinationally from the FIFO head when issue_fire=1, and held at 0 otherwise.
  - On issue_fire, the head is popped and credits are decremented.
  - Tag, dz and ovf move into a 1-stage in-flight register, and inflight_v=1 at the next edge.
- Capture: when inflight_v=1, alu_result at that cycle is written to the result buffer with the in-flight tag and flags.
  - If dz=1, the stored result is 5'd0.
  - Capture never fails, because credits guarantee a free slot.
- Output: out_* shows the result buffer head.
  - On out_valid && out_ready, the head is popped and credits are incremented.
  - Invariant: credits + inflight_v + result occupancy == RES_DEPTH.
- Simultaneous events:
  - Accept and issue in the same cycle: cmd_count is unchanged.
  - Pop and issue in the same cycle: credits are unchanged, and issue is allowed even when credits==0 before the pop. Credit increment from the pop is visible to issue in the same cycle.
  - Full FIFO with a pop in the same cycle: in_ready stays 0 (no combinational path from issue to in_ready).
- Throughput: 1 op/cycle sustained while out_ready=1 and RES_DEPTH>=2.
- Ordering: results leave in strict acceptance order.
- Reset mid-operation: in-flight and buffered results are discarded. The ALU output for the cycle after reset release is ignored because inflight_v=0.
- Flag rules:
  - ovf applies to sel=100 (mul) when the full 8-bit product > 31, and to sel=001 (sub) when B>A.
  - For every other op, ovf=0.
  - dz applies only to sel=110/111 with B==0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (ADD, SUB, AND, OR, MUL, XOR, MOD, DIV), 3 bits;
  - the struct cmd_t {a, b, op, tag, dz, ovf};
  - the struct res_t {result, tag, dz, ovf};
  - the function calc_flags(a, b, op).
- One sub-module: sync_fifo, parameterised by width and depth, with full/empty/count outputs. It is instantiated twice (command FIFO, result buffer).

Test Plan:
- Reset, then send A=3,B=5,sel=000,tag=1 with out_ready=1 → out_valid 3 cycles after accept with result=8, tag=1, dz=0, ovf=0. The cycle count includes accept, issue and capture.
- A=7,B=0,sel=111,tag=2, then A=9,B=0,sel=110,tag=3 → result=0 with dz=1 for both, in order 2,3.
- A=6,B=7,sel=100 → ovf=1 and result=42 mod 32=10. A=2,B=5,sel=001 → ovf=1 and result=5'b11101.
- out_ready=0 while pushing 6 commands → exactly RES_DEPTH issued, cmd FIFO full and in_ready=0. Then out_ready=1 → all 6 drain in order with no loss or duplication.
- Back-to-back 16 random ops with out_ready=1 → one result per cycle after the pipeline fills. Results match a reference model, with 5-bit truncation for mul/sub.
- Assert reset with 2 in flight and 2 buffered → next cycle out_valid=0, cmd_count=0, and no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and flag helper for the ALU issue controller
// Contents: alu_op_e opcode enum, cmd_t command FIFO entry, res_t result
// buffer entry, flags_t, calc_flags() precomputing dz/ovf at accept time.
package alu_pkg;

    // Tag storage width inside the packed entries; the top's TAG_W must not exceed it.
    localparam int TAG_W_MAX = 8;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        MUL = 3'b100,
        XOR = 3'b101,
        MOD = 3'b110,
        DIV = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [3:0]           a;
        logic [3:0]           b;
        alu_op_e              op;
        logic [TAG_W_MAX-1:0] tag;
        logic                 dz;
        logic                 ovf;
    } cmd_t;

    typedef struct packed {
        logic [4:0]           result;
        logic [TAG_W_MAX-1:0] tag;
        logic                 dz;
        logic                 ovf;
    } res_t;

    typedef struct packed {
        logic dz;
        logic ovf;
    } flags_t;

    // ovf: mul whose full 8-bit product exceeds 31, or sub that borrows (B > A).
    // dz: mod/div by zero. Every other case reports neither flag.
    function automatic flags_t calc_flags(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input alu_op_e    op);
        flags_t     f;
        logic [7:0] prod;
        prod  = {4'b0000, a} * {4'b0000, b};
        f.dz  = ((op == MOD) || (op == DIV)) && (b == 4'd0);
        f.ovf = ((op == MUL) && (prod > 8'd31)) || ((op == SUB) && (b > a));
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word fall-through read port
// Ports: clk, reset (sync, active-low), wr_en/wr_data (ignored when full),
// rd_en (ignored when empty), rd_data (current head), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command buffering, credit-based issue and result return for the 4-bit ALU
// Ports: clk, reset (sync, active-low); command in: in_valid/in_ready/in_a/in_b/in_sel/in_tag;
// ALU side: alu_a/alu_b/alu_sel out, alu_result in (one cycle after issue);
// result out: out_valid/out_ready/out_result/out_tag/out_dz/out_ovf; cmd_count = command FIFO occupancy.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_a,
    input  logic [3:0]                   in_b,
    input  logic [2:0]                   in_sel,
    input  logic [TAG_W-1:0]             in_tag,
    output logic [3:0]                   alu_a,
    output logic [3:0]                   alu_b,
    output logic [2:0]                   alu_sel,
    input  logic [4:0]                   alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0]                   out_result,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_dz,
    output logic                         out_ovf,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

    localparam int CRW = $clog2(RES_DEPTH) + 1;

    cmd_t                      w_cmd_in;
    cmd_t                      w_cmd_head;
    flags_t                    w_flags;
    logic                      w_cmd_full;
    logic                      w_cmd_empty;
    logic [$clog2(CMD_DEPTH):0] w_cmd_count;

    res_t                      w_res_in;
    res_t                      w_res_head;
    logic                      w_res_full;
    logic                      w_res_empty;
    logic [$clog2(RES_DEPTH):0] w_res_count;

    logic                      w_accept;
    logic                      w_issue;
    logic                      w_out_pop;

    logic [CRW-1:0]            r_credits;
    logic                      r_inflight_v;
    logic [TAG_W_MAX-1:0]      r_inflight_tag;
    logic                      r_inflight_dz;
    logic                      r_inflight_ovf;

    // Status bits the control path does not need; credits already bound occupancy.
    logic                      w_unused;
    assign w_unused = ^{w_res_full, w_res_count, w_res_head.tag};

    // in_ready depends only on registered occupancy, so a same-cycle issue
    // never reopens a full FIFO.
    assign in_ready  = reset && !w_cmd_full;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_res_empty;
    assign w_out_pop = out_valid && out_ready;
    // A same-cycle pop frees a slot, so it counts as a credit for this issue.
    assign w_issue   = !w_cmd_empty && ((r_credits != '0) || w_out_pop);
    assign cmd_count = w_cmd_count;

    assign w_flags = calc_flags(in_a, in_b, alu_op_e'(in_sel));

    always_comb begin
        w_cmd_in     = '0;
        w_cmd_in.a   = in_a;
        w_cmd_in.b   = in_b;
        w_cmd_in.op  = alu_op_e'(in_sel);
        w_cmd_in.tag = TAG_W_MAX'(in_tag);
        w_cmd_in.dz  = w_flags.dz;
        w_cmd_in.ovf = w_flags.ovf;
    end

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_accept),
        .wr_data (w_cmd_in),
        .rd_en   (w_issue),
        .rd_data (w_cmd_head),
        .full    (w_cmd_full),
        .empty   (w_cmd_empty),
        .count   (w_cmd_count)
    );

    assign alu_a   = w_issue ? w_cmd_head.a  : 4'd0;
    assign alu_b   = w_issue ? w_cmd_head.b  : 4'd0;
    assign alu_sel = w_issue ? w_cmd_head.op : 3'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credits      <= CRW'(RES_DEPTH);
            r_inflight_v   <= 1'b0;
            r_inflight_tag <= '0;
            r_inflight_dz  <= 1'b0;
            r_inflight_ovf <= 1'b0;
        end else begin
            r_credits    <= r_credits + CRW'(w_out_pop) - CRW'(w_issue);
            r_inflight_v <= w_issue;
            if (w_issue) begin
                r_inflight_tag <= w_cmd_head.tag;
                r_inflight_dz  <= w_cmd_head.dz;
                r_inflight_ovf <= w_cmd_head.ovf;
            end
        end
    end

    // Divide-by-zero results are forced to zero regardless of what the ALU returns.
    always_comb begin
        w_res_in        = '0;
        w_res_in.result = r_inflight_dz ? 5'd0 : alu_result;
        w_res_in.tag    = r_inflight_tag;
        w_res_in.dz     = r_inflight_dz;
        w_res_in.ovf    = r_inflight_ovf;
    end

    sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (r_inflight_v),
        .wr_data (w_res_in),
        .rd_en   (w_out_pop),
        .rd_data (w_res_head),
        .full    (w_res_full),
        .empty   (w_res_empty),
        .count   (w_res_count)
    );

    // Head is masked while empty so stale storage never shows on the outputs.
    assign out_result = out_valid ? w_res_head.result           : 5'd0;
    assign out_tag    = out_valid ? w_res_head.tag[TAG_W-1:0]   : '0;
    assign out_dz     = out_valid ? w_res_head.dz               : 1'b0;
    assign out_ovf    = out_valid ? w_res_head.ovf              : 1'b0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with an ALU stand-in and result model
module tb_alu_issue_ctrl;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_a = '0;
    logic [3:0]       in_b = '0;
    logic [2:0]       in_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_sel;
    logic [4:0]       alu_result = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_dz;
    logic             out_ovf;
    logic [2:0]       cmd_count;

    typedef struct packed {
        logic [4:0]       result;
        logic [TAG_W-1:0] tag;
        logic             dz;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t g_got;
    exp_t g_exp;
    logic g_popped;
    logic g_have_exp;
    logic g_acc;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl #(.CMD_DEPTH(4), .RES_DEPTH(2), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_dz     (out_dz),
        .out_ovf    (out_ovf),
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;

    // ALU stand-in: registered, one-cycle latency; returns garbage on divide by zero.
    function automatic logic [4:0] alu_stub(logic [3:0] a, logic [3:0] b, logic [2:0] s);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return p[4:0];
            3'd5:    return {1'b0, a ^ b};
            3'd6:    return (b == 4'd0) ? 5'h1f : {1'b0, a % b};
            default: return (b == 4'd0) ? 5'h1f : {1'b0, a / b};
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_stub(alu_a, alu_b, alu_sel);

    // Reference: integer arithmetic reduced modulo 32, flags from the op rules.
    function automatic exp_t model(int a, int b, int sel, int tag);
        exp_t e;
        int   r;
        case (sel)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a * b;
            5: r = a ^ b;
            6: r = (b == 0) ? 0 : a % b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        e.result = 5'(r & 31);
        e.tag    = TAG_W'(tag);
        e.dz     = (sel >= 6) && (b == 0);
        e.ovf    = ((sel == 4) && (a * b > 31)) || ((sel == 1) && (b > a));
        return e;
    endfunction

    // One clock: record accept into the model, record any pop, advance past the edge.
    task automatic tick();
        #1;
        g_acc = in_valid && in_ready;
        if (g_acc === 1'b1) exp_q.push_back(model(in_a, in_b, in_sel, in_tag));
        g_popped = (out_valid && out_ready) === 1'b1;
        g_have_exp = 1'b0;
        if (g_popped) begin
            g_got = '{out_result, out_tag, out_dz, out_ovf};
            if (exp_q.size() > 0) begin
                g_exp = exp_q.pop_front();
                g_have_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(int a, int b, int sel, int tag);
        in_a = 4'(a); in_b = 4'(b); in_sel = 3'(sel); in_tag = TAG_W'(tag);
    endtask

    task automatic set_rand_cmd(int tag);
        set_cmd($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                $urandom_range(0, 7), tag);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || cmd_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctl in_ready=%b out_valid=%b cmd_count=%0d required 0 0 0", in_ready, out_valid, cmd_count);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 11'd0) begin
            errors++;
            $display("FAIL reset_alu got %h required 0", {alu_a, alu_b, alu_sel});
        end
        checks++;
        if ({out_result, out_tag, out_dz, out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_out got %h required 0", {out_result, out_tag, out_dz, out_ovf});
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   n;
        out_ready = 1'b1;
        in_valid = 1'b1; set_cmd(3, 5, 0, 1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_a !== 4'd3 || alu_b !== 4'd5 || alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL single_issue alu=%h/%h/%h required 3/5/0", alu_a, alu_b, alu_sel);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 out_valid=%b required 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 out_valid=%b required 0", out_valid); end
        tick();
        e = '{5'd8, 4'd1, 1'b0, 1'b0};
        checks++;
        if (out_valid !== 1'b1 || {out_result, out_tag, out_dz, out_ovf} !== e) begin
            errors++;
            $display("FAIL single_result valid=%b got %h required %h", out_valid, {out_result, out_tag, out_dz, out_ovf}, e);
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (g_popped) begin
                n++;
                checks++;
                if (!g_have_exp || g_got !== g_exp) begin
                    errors++; $display("FAIL single_pop got %h required %h", g_got, g_exp);
                end
            end
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL single_count got %0d required 1", n); end
    endtask

    // Two fixed commands, each popped result checked against constants and the model.
    task automatic test_pair(string name, int a0, int b0, int s0, int t0, exp_t e0,
                             int a1, int b1, int s1, int t1, exp_t e1);
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; set_cmd(a0, b0, s0, t0);
        tick();
        set_cmd(a1, b1, s1, t1);
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (g_popped) begin
                checks++;
                if (g_got !== ((n == 0) ? e0 : e1)) begin
                    errors++; $display("FAIL %s_fixed%0d got %h required %h", name, n, g_got, (n == 0) ? e0 : e1);
                end
                checks++;
                if (!g_have_exp || g_got !== g_exp) begin
                    errors++; $display("FAIL %s_model%0d got %h required %h", name, n, g_got, g_exp);
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL %s_count got %0d required 2", name, n); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rand_cmd(6 + i);
            tick();
            checks++;
            if (g_acc !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b required 1", i, g_acc); end
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (cmd_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full cmd_count=%0d in_ready=%b out_valid=%b required 4 0 1", cmd_count, in_ready, out_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 11'd0) begin
            errors++; $display("FAIL bp_no_issue alu got %h required 0", {alu_a, alu_b, alu_sel});
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pop in_ready=%b required 0", in_ready); end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (g_popped) begin
                n++;
                checks++;
                if (!g_have_exp || g_got !== g_exp) begin
                    errors++; $display("FAIL bp_drain got %h required %h", g_got, g_exp);
                end
            end
        end
        checks++;
        if (n != 6 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_drain_count got %0d left %0d required 6 0", n, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int first_pop;
        int last_pop;
        int n;
        int acc;
        first_pop = -1; last_pop = -1; n = 0; acc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 16) set_rand_cmd(cyc);
            else in_valid = 1'b0;
            tick();
            if (g_acc === 1'b1) acc++;
            if (cyc == 8) begin
                checks++;
                if (cmd_count !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d required 1", cmd_count); end
            end
            if (g_popped) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n++;
                checks++;
                if (!g_have_exp || g_got !== g_exp) begin
                    errors++; $display("FAIL b2b_result got %h required %h", g_got, g_exp);
                end
            end
        end
        checks++;
        if (acc != 16 || n != 16) begin errors++; $display("FAIL b2b_total accepted %0d popped %0d required 16 16", acc, n); end
        checks++;
        if (first_pop != 3 || last_pop - first_pop != 15) begin
            errors++; $display("FAIL b2b_rate first %0d last %0d required 3 18", first_pop, last_pop);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand_cmd(10 + i);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || cmd_count !== 3'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out_valid=%b cmd_count=%0d in_ready=%b required 0 0 0", out_valid, cmd_count, in_ready);
        end
        reset = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (g_popped || out_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL mid_stale got %0d stale cycles required 0", n); end
        in_valid = 1'b1; set_cmd(4, 4, 4, 15);
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (g_popped) begin
                n++;
                checks++;
                if (!g_have_exp || g_got !== g_exp || g_got !== exp_t'({5'd16, 4'd15, 1'b0, 1'b0})) begin
                    errors++; $display("FAIL mid_after got %h required %h", g_got, g_exp);
                end
            end
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL mid_after_count got %0d required 1", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair("dz", 7, 0, 7, 2, exp_t'({5'd0, 4'd2, 1'b1, 1'b0}),
                        9, 0, 6, 3, exp_t'({5'd0, 4'd3, 1'b1, 1'b0}));
        test_pair("ovf", 6, 7, 4, 4, exp_t'({5'd10, 4'd4, 1'b0, 1'b1}),
                         2, 5, 1, 5, exp_t'({5'b11101, 4'd5, 1'b0, 1'b1}));
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
